// File: rtl/se_sram_port_ctrl_pkg.sv
// Shared definitions for the SRAM port front-end: controller states and
// response buffer depth.
package se_sram_port_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_INIT  = 2'd1,
    ST_RUN   = 2'd2
  } ctrl_state_e;

  localparam int unsigned RSP_BUF_DEPTH = 3;
  localparam int unsigned RSP_CNT_W     = 2;

endpackage

// File: rtl/se_fifo_3_reg.sv
// Three-entry register FIFO; entry 0 is always the head, pops shift the rest down.
module se_fifo_3_reg
  import se_sram_port_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [RSP_CNT_W-1:0]  count_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DATA_WIDTH-1:0] mem_q [RSP_BUF_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [RSP_BUF_DEPTH];
  logic [RSP_CNT_W-1:0]  count_q, count_d;
  logic [RSP_CNT_W-1:0]  wr_idx;

  // On a simultaneous pop the write slot moves down with the shifted entries.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    wr_idx  = count_q;
    if (pop_i) begin
      for (int unsigned i = 0; i < RSP_BUF_DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      wr_idx = count_q - RSP_CNT_W'(1);
    end
    if (push_i) begin
      for (int unsigned i = 0; i < RSP_BUF_DEPTH; i++) begin
        if (RSP_CNT_W'(i) == wr_idx) begin
          mem_d[i] = push_data_i;
        end
      end
    end
    count_d = count_q + RSP_CNT_W'(push_i) - RSP_CNT_W'(pop_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RSP_BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign data_o  = mem_q[0];

endmodule

// File: rtl/se_sram_port_ctrl.sv
// Valid/ready front-end for one SRAM port: clears the array after reset, then
// forwards requests and buffers read data against consumer stalls.
module se_sram_port_ctrl
  import se_sram_port_ctrl_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 9,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_read_not_write,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0] req_write_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  init_busy,
  output logic                  sram_select,
  output logic                  sram_read_not_write,
  output logic [ADDR_WIDTH-1:0] sram_address,
  output logic [DATA_WIDTH-1:0] sram_write_data,
  input  logic [DATA_WIDTH-1:0] sram_read_data
);

  ctrl_state_e           state_q;
  logic [ADDR_WIDTH-1:0] init_cnt_q;
  logic                  inflight_q;
  logic [RSP_CNT_W-1:0]  buf_count;
  logic [2:0]            credit_used;
  logic                  req_accept;
  logic                  rd_accept;
  logic                  rsp_pop;

  // Credit counts buffered entries plus the read whose data lands next cycle.
  assign credit_used = 3'(buf_count) + 3'(inflight_q);
  assign req_ready   = (state_q == ST_RUN) && (credit_used < 3'(RSP_BUF_DEPTH));
  assign req_accept  = req_valid && req_ready;
  assign rd_accept   = req_accept && req_read_not_write;
  assign rsp_pop     = rsp_valid && rsp_ready;
  assign init_busy   = (state_q != ST_RUN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_START;
      init_cnt_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_accept;
      case (state_q)
        ST_START: begin
          state_q    <= ST_INIT;
          init_cnt_q <= '0;
        end
        ST_INIT: begin
          if (&init_cnt_q) begin
            state_q <= ST_RUN;
          end else begin
            init_cnt_q <= init_cnt_q + ADDR_WIDTH'(1);
          end
        end
        ST_RUN:  state_q <= ST_RUN;
        default: state_q <= ST_START;
      endcase
    end
  end

  // SRAM port mux: idle, clearing sweep, or pass-through of the live request.
  always_comb begin
    sram_select         = 1'b0;
    sram_read_not_write = 1'b1;
    sram_address        = '0;
    sram_write_data     = '0;
    case (state_q)
      ST_INIT: begin
        sram_select         = 1'b1;
        sram_read_not_write = 1'b0;
        sram_address        = init_cnt_q;
        sram_write_data     = INIT_VALUE;
      end
      ST_RUN: begin
        sram_select         = req_accept;
        sram_read_not_write = req_read_not_write;
        sram_address        = req_address;
        sram_write_data     = req_write_data;
      end
      default: ;
    endcase
  end

  se_fifo_3_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rsp_buf (
    .clk         (clk),
    .rst_n       (reset_n),
    .push_i      (inflight_q),
    .push_data_i (sram_read_data),
    .pop_i       (rsp_pop),
    .count_o     (buf_count),
    .data_o      (rsp_data)
  );

  assign rsp_valid = (buf_count != '0);

endmodule

// File: tb/tb_se_sram_port_ctrl.sv
// Directed bench for se_sram_port_ctrl with a behavioural synchronous SRAM.
module tb_se_sram_port_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam logic [DW-1:0] IV = 32'hDEADBEEF;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_read_not_write = 1'b1;
  logic [AW-1:0] req_address = '0;
  logic [DW-1:0] req_write_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          init_busy;
  logic          sram_select;
  logic          sram_read_not_write;
  logic [AW-1:0] sram_address;
  logic [DW-1:0] sram_write_data;
  logic [DW-1:0] sram_read_data = '0;

  logic [DW-1:0] mem [2**AW];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          vld;
    logic          rnw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic          rr;
    logic          e_rdy;
    logic          e_vld;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t tbl[$];

  se_sram_port_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .INIT_VALUE (IV)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_read_not_write  (req_read_not_write),
    .req_address         (req_address),
    .req_write_data      (req_write_data),
    .rsp_valid           (rsp_valid),
    .rsp_ready           (rsp_ready),
    .rsp_data            (rsp_data),
    .init_busy           (init_busy),
    .sram_select         (sram_select),
    .sram_read_not_write (sram_read_not_write),
    .sram_address        (sram_address),
    .sram_write_data     (sram_write_data),
    .sram_read_data      (sram_read_data)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM: read data appears the cycle after a selected read.
  always @(posedge clk) begin
    if (sram_select) begin
      if (sram_read_not_write) sram_read_data <= mem[sram_address];
      else                     mem[sram_address] <= sram_write_data;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic vld, input logic rnw, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wd, input logic rr, input logic e_rdy,
                              input logic e_vld, input logic [DW-1:0] e_data);
    vec_t v;
    v.vld = vld; v.rnw = rnw; v.addr = addr; v.wd = wd; v.rr = rr;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_data = e_data;
    return v;
  endfunction

  task automatic drive_idle();
    req_valid = 1'b0;
    req_read_not_write = 1'b1;
    req_address = '0;
    req_write_data = '0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(posedge clk);
    #1;
    req_valid = v.vld;
    req_read_not_write = v.rnw;
    req_address = v.addr;
    req_write_data = v.wd;
    rsp_ready = v.rr;
    @(negedge clk);
    chk({tag, ".req_ready"}, DW'(req_ready), DW'(v.e_rdy));
    chk({tag, ".rsp_valid"}, DW'(rsp_valid), DW'(v.e_vld));
    if (v.e_vld) chk({tag, ".rsp_data"}, rsp_data, v.e_data);
    chk({tag, ".init_busy"}, DW'(init_busy), DW'(1'b0));
    chk({tag, ".sram_select"}, DW'(sram_select), DW'(v.vld & v.e_rdy));
  endtask

  // Pulse reset (checking reset values while low), release, and check the clear sweep.
  task automatic reset_and_init(input string tag);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    drive_idle();
    rsp_ready = 1'b0;
    #1;
    chk({tag, ".rst.req_ready"}, DW'(req_ready), DW'(1'b0));
    chk({tag, ".rst.rsp_valid"}, DW'(rsp_valid), DW'(1'b0));
    chk({tag, ".rst.init_busy"}, DW'(init_busy), DW'(1'b1));
    chk({tag, ".rst.sram_select"}, DW'(sram_select), DW'(1'b0));
    chk({tag, ".rst.sram_rnw"}, DW'(sram_read_not_write), DW'(1'b1));
    chk({tag, ".rst.sram_address"}, DW'(sram_address), DW'(0));
    chk({tag, ".rst.sram_write_data"}, sram_write_data, DW'(0));
    chk({tag, ".rst.rsp_data"}, rsp_data, DW'(0));
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk({tag, ".start.init_busy"}, DW'(init_busy), DW'(1'b1));
    chk({tag, ".start.sram_select"}, DW'(sram_select), DW'(1'b0));
    for (int k = 1; k <= 2**AW; k++) begin
      @(negedge clk);
      chk($sformatf("%s.init%0d.busy", tag, k), DW'(init_busy), DW'(1'b1));
      chk($sformatf("%s.init%0d.ready", tag, k), DW'(req_ready), DW'(1'b0));
      chk($sformatf("%s.init%0d.rsp_valid", tag, k), DW'(rsp_valid), DW'(1'b0));
      chk($sformatf("%s.init%0d.select", tag, k), DW'(sram_select), DW'(1'b1));
      chk($sformatf("%s.init%0d.rnw", tag, k), DW'(sram_read_not_write), DW'(1'b0));
      chk($sformatf("%s.init%0d.addr", tag, k), DW'(sram_address), DW'(k - 1));
      chk($sformatf("%s.init%0d.wdata", tag, k), sram_write_data, IV);
    end
  endtask

  initial begin
    // Reset release: read 7 returns the clear value two cycles later.
    tbl.push_back(mk(1, 1, 4'd7, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 4'd0, 0, 1, 1, 0, 0));
    // Write 3 then read 3 on the next cycle.
    tbl.push_back(mk(1, 0, 4'd3, 32'h0000_1234, 1, 1, 1, IV));
    tbl.push_back(mk(1, 1, 4'd3, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 4'd0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 4'd0, 0, 1, 1, 1, 32'h0000_1234));
    tbl.push_back(mk(0, 1, 4'd0, 0, 1, 1, 0, 0));
    // Fill addresses with their index, then stream reads 0..15.
    for (int i = 0; i < 16; i++) tbl.push_back(mk(1, 0, AW'(i), DW'(i), 1, 1, 0, 0));
    for (int j = 0; j < 16; j++)
      tbl.push_back(mk(1, 1, AW'(j), 0, 1, 1, (j >= 2), DW'(j - 2)));
    tbl.push_back(mk(0, 1, 4'd0, 0, 1, 1, 1, DW'(14)));
    tbl.push_back(mk(0, 1, 4'd0, 0, 1, 1, 1, DW'(15)));
    tbl.push_back(mk(0, 1, 4'd0, 0, 1, 1, 0, 0));
    // Backpressure: fourth read stalls until the consumer drains one entry.
    tbl.push_back(mk(1, 1, 4'd1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 4'd2, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 4'd3, 0, 0, 1, 1, DW'(1)));
    tbl.push_back(mk(1, 1, 4'd4, 0, 0, 0, 1, DW'(1)));
    tbl.push_back(mk(1, 1, 4'd4, 0, 0, 0, 1, DW'(1)));
    tbl.push_back(mk(1, 1, 4'd4, 0, 1, 0, 1, DW'(1)));
    tbl.push_back(mk(1, 1, 4'd4, 0, 1, 1, 1, DW'(2)));
    tbl.push_back(mk(0, 1, 4'd0, 0, 1, 1, 1, DW'(3)));
    tbl.push_back(mk(0, 1, 4'd0, 0, 1, 1, 1, DW'(4)));
    tbl.push_back(mk(0, 1, 4'd0, 0, 1, 1, 0, 0));

    reset_and_init("por");
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset with two responses buffered.
    run_vec(mk(1, 1, 4'd5, 0, 0, 1, 0, 0), "mid0");
    run_vec(mk(1, 1, 4'd6, 0, 0, 1, 0, 0), "mid1");
    run_vec(mk(0, 1, 4'd0, 0, 0, 1, 1, DW'(5)), "mid2");
    run_vec(mk(0, 1, 4'd0, 0, 0, 1, 1, DW'(5)), "mid3");
    reset_and_init("mid");
    run_vec(mk(0, 1, 4'd0, 0, 1, 1, 0, 0), "post0");
    run_vec(mk(1, 1, 4'd5, 0, 1, 1, 0, 0), "post1");
    run_vec(mk(0, 1, 4'd0, 0, 1, 1, 0, 0), "post2");
    run_vec(mk(0, 1, 4'd0, 0, 1, 1, 1, IV), "post3");
    run_vec(mk(0, 1, 4'd0, 0, 1, 1, 0, 0), "post4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/se_sram_port_ctrl.md
# se_sram_port_ctrl

Valid/ready request front-end for one port of a dual-port SRAM (se_sram_mrw_2_* family). Clears the whole array to a constant after reset, then accepts read/write requests and drives the SRAM port. Absorbs the SRAM's one-cycle read latency with a 3-entry response buffer, so a stalling consumer never loses data. One instance per SRAM port; the SRAM's data_out_N feeds sram_read_data.

## Interface
- ADDR_WIDTH, 9, SRAM address width; array depth is 2^ADDR_WIDTH
- DATA_WIDTH, 32, SRAM data width
- INIT_VALUE, 0, word written to every address during initialisation
- clk  in  1  single clock; also clocks the attached SRAM port
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid && ready
- req_read_not_write  in  1  1 = read, 0 = write
- req_address  in  ADDR_WIDTH  request address
- req_write_data  in  DATA_WIDTH  write data
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer takes data when valid && ready
- rsp_data  out  DATA_WIDTH  read data, in request order
- init_busy  out  1  high while array is being cleared
- sram_select  out  1  to SRAM select_N
- sram_read_not_write  out  1  to SRAM read_not_write_N
- sram_address  out  ADDR_WIDTH  to SRAM address_N
- sram_write_data  out  DATA_WIDTH  to SRAM write_data_N
- sram_read_data  in  DATA_WIDTH  from SRAM data_out_N, valid the cycle after a selected read

## Operation
- States: START -> INIT -> RUN. Reset forces START from any state.
- START: one cycle, SRAM port idle, then INIT.
- INIT: init counter from 0; each cycle sram_select=1, read_not_write=0, address=counter, write_data=INIT_VALUE. After writing 2^ADDR_WIDTH-1, go to RUN. Counter never wraps.
- RUN: sram_select = req_valid && req_ready; SRAM address/rnw/write_data driven combinationally from the req_* inputs.
- req_ready = (state==RUN) && (buffered + inflight < 3), computed from registers only. Writes are gated identically, for simplicity.
- inflight: 1-bit register, set when a read is accepted, cleared the next cycle. On that next cycle sram_read_data is pushed into the buffer.
- Response buffer: 3-entry FIFO with occupancy 0..3. Push and pop in the same cycle keeps occupancy unchanged. Overflow is impossible by the credit rule.
- Writes produce no response. Accepted requests reach the SRAM port in acceptance order.
- Reset mid-operation: buffer, inflight and pending responses are discarded, and the array is re-cleared.

## Timing
- Reset values:
  - req_ready=0, rsp_valid=0, init_busy=1
  - sram_select=0, sram_read_not_write=1
  - sram_address=0, sram_write_data=0, rsp_data=0
- init_busy stays high from reset through the last INIT cycle; it is low in the first RUN cycle. INIT lasts exactly 2^ADDR_WIDTH cycles.
- First req_ready: cycle 2^ADDR_WIDTH+1 after reset release (START=cycle 0).
- Read accepted in cycle N: the SRAM samples at the end of N, data is pushed at the end of N+1, and rsp_valid is high in N+2 (latency 2).
- With rsp_ready held high, one read is accepted per cycle indefinitely.
- With rsp_ready low, req_ready drops after 3 outstanding reads and rises the cycle after occupancy+inflight falls below 3.

## Structure
- State encoding (START/INIT/RUN) and the buffer depth constant (3) go in the shared SRAM-support package.
- One sub-module: se_fifo_3_reg, a 3-entry register FIFO with push, pop, occupancy and data outputs.
- The state machine, init counter, inflight flag and credit logic live in the top level.

## Test plan
All scenarios use ADDR_WIDTH=4, DATA_WIDTH=32, INIT_VALUE=32'hDEADBEEF.
- Reset release:
  - init_busy high for 16 cycles after START, with SRAM writes to addresses 0..15 in order.
  - req_ready first rises at cycle 17.
  - Read of address 7 then returns 32'hDEADBEEF two cycles after acceptance.
- Write/read order: write 32'h0000_1234 to address 3, then read address 3 in the next cycle -> rsp_data=32'h0000_1234.
- Back-to-back reads:
  - Setup: addresses 0..15 hold their index; rsp_ready=1.
  - Stimulus: read addresses 0..15 on consecutive cycles.
  - Required: rsp_valid high for 16 consecutive cycles with data 0..15, and req_ready never drops.
- Backpressure:
  - Stimulus: rsp_ready=0; issue reads of addresses 1,2,3,4.
  - Required: the 4th read stalls (req_ready=0 after 3 accepts).
  - Then raise rsp_ready: responses arrive in order 1,2,3, then 4 after it is accepted; none lost or duplicated.
- Reset mid-operation: assert reset_n low with 2 responses buffered -> rsp_valid=0 immediately, no stale data after release, and the array is re-cleared to 32'hDEADBEEF.
